alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 16-bit combinational arithmetic unit.
- Provides 16 arithmetic functions (mode=0) and 16 logic functions (mode=1) on WIDTH-bit operands.
- Uses a valid/ready handshake on input and output, with a single result register stage.
- Holds a carry register, so multi-word add/subtract can be chained across successive transactions.
- Sits between the datapath operand muxes and the writeback/flag logic.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in, used when in_chain=0.
- in_chain  in  1  1: use stored carry_q as carry-in instead of in_cin.
- in_mode  in  1  0 arithmetic, 1 logic.
- in_sel  in  4  function select.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  function result.
- out_cout  out  1  carry-out; 0 for logic ops.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].
- out_equal  out  1  in_a == in_b for that transaction.

Behaviour:
- Accept happens when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, so there are no bubbles under continuous flow.
- On accept, the result and flags are registered. out_valid=1 in the next cycle, so latency is 1 cycle.
- out_valid clears on out_ready without a new accept. Accept and drain in the same cycle keeps out_valid=1 and loads the new result.
- While out_valid && !out_ready: all out_* hold stable and in_ready=0.
- Effective carry-in is c = in_chain ? carry_q : in_cin.
- Arithmetic op: compute X + Y + c with X and Y zero-extended to WIDTH+1 bits. out_result = low WIDTH bits; out_cout = bit WIDTH. ONES = all-ones WIDTH-bit vector.
  - sel 0: X=A, Y=0
  - sel 1: X=A|B, Y=0
  - sel 2: X=A|~B, Y=0
  - sel 3: X=ONES, Y=0
  - sel 4: X=A, Y=A&~B
  - sel 5: X=A|B, Y=A&~B
  - sel 6: X=A, Y=~B
  - sel 7: X=A&~B, Y=ONES
  - sel 8: X=A, Y=A&B
  - sel 9: X=A, Y=B
  - sel 10: X=A|~B, Y=A&B
  - sel 11: X=A&B, Y=ONES
  - sel 12: X=A, Y=A
  - sel 13: X=A|B, Y=A
  - sel 14: X=A|~B, Y=A
  - sel 15: X=A, Y=ONES
- Logic op: result is bitwise, out_cout=0, carry-in is ignored.
  - sel 0: ~A
  - sel 1: ~(A|B)
  - sel 2: ~A&B
  - sel 3: 0
  - sel 4: ~(A&B)
  - sel 5: ~B
  - sel 6: A^B
  - sel 7: A&~B
  - sel 8: ~A|B
  - sel 9: ~(A^B)
  - sel 10: B
  - sel 11: A&B
  - sel 12: ONES
  - sel 13: A|~B
  - sel 14: A|B
  - sel 15: A
- carry_q updates to the arithmetic carry-out on every accepted arithmetic op. Logic ops leave carry_q unchanged. Non-accepted cycles never change carry_q.
- Chain with simultaneous update: an accepted op with in_chain=1 reads the carry_q value from before this edge.
- Reset (rst_n=0 at an edge) sets:
  - out_valid=0
  - out_result=0, out_cout=0
  - out_zero=1, out_neg=0, out_equal=0
  - carry_q=0
- Reset mid-transfer discards the pending result. in_ready=1 in the first cycle after reset release.
- Inputs are don't-care when in_valid=0. The state machine is implicit: EMPTY (out_valid=0) and FULL (out_valid=1).

Optional Feature:
- Macro: ALU_PIPE_OVF_EN.
- Defined: adds output out_ovf (1 bit) = signed two's-complement overflow of the arithmetic op (X, Y, c). It is defined as carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_ovf is 0 for logic ops.
  - Reset value 0; registered and held like the other flags.
- Undefined: the out_ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=16, mode0 sel9, A=0xFFFF B=0x0001 cin=0 -> next cycle out_valid=1, result=0x0000, cout=1, zero=1, equal=0.
- Follow with mode0 sel9 A=0x0000 B=0x0000 chain=1 cin=0 -> result=0x0001, cout=0. Carry is consumed from carry_q=1.
- mode0 sel6 A=0x0005 B=0x0003 cin=1 -> result=0x0002, cout=1. Then mode1 sel6 A=0x00F0 B=0x0FF0 -> result=0x0F00, cout=0, carry_q still 1.
- Hold out_ready=0 and present 2 back-to-back ops -> second op sees in_ready=0 and the first result stays stable. Raise out_ready -> second op accepted in that cycle and its result appears next cycle with no bubble.
- Assert rst_n=0 while out_valid=1 -> out_valid=0, carry_q=0, zero=1. Then chain op mode0 sel0 A=0x1234 -> result=0x1234, cout=0.
- With ALU_PIPE_OVF_EN: mode0 sel9 A=0x7FFF B=0x0001 -> result=0x8000, neg=1, ovf=1, cout=0. Without the macro, the same op builds with no out_ovf port.

Source files
------------

// File: rtl/alu_pipe.sv
// Purpose : registered 32-function ALU (16 arithmetic, 16 logic) with a chainable carry register.
// Latency : 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpr. : in_ready = !out_valid || out_ready; a stalled result holds all out_* stable.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          request handshake
//   in_a, in_b                 WIDTH-bit operands
//   in_cin, in_chain           carry-in; in_chain=1 selects the stored carry instead
//   in_mode, in_sel            0 arithmetic / 1 logic, 4-bit function select
//   out_valid/out_ready        result handshake
//   out_result, out_cout       result and carry-out (0 for logic ops)
//   out_zero, out_neg          result flags
//   out_equal                  in_a == in_b for the transaction
//   out_ovf                    signed overflow, present only when ALU_PIPE_OVF_EN is defined
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_chain,
    input  logic             in_mode,
    input  logic [3:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
`ifdef ALU_PIPE_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_equal
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic             carry_q;
    logic             accept;
    logic             cin_eff;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_cout;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // carry_q is read before this edge's update, so a chained op sees the previous carry.
    assign cin_eff = in_chain ? carry_q : in_cin;

    // Arithmetic operand selection: result = X + Y + c.
    always_comb begin
        op_x = in_a;
        op_y = '0;
        case (in_sel)
            4'd0:  begin op_x = in_a;           op_y = '0;              end
            4'd1:  begin op_x = in_a | in_b;    op_y = '0;              end
            4'd2:  begin op_x = in_a | ~in_b;   op_y = '0;              end
            4'd3:  begin op_x = ONES;           op_y = '0;              end
            4'd4:  begin op_x = in_a;           op_y = in_a & ~in_b;    end
            4'd5:  begin op_x = in_a | in_b;    op_y = in_a & ~in_b;    end
            4'd6:  begin op_x = in_a;           op_y = ~in_b;           end
            4'd7:  begin op_x = in_a & ~in_b;   op_y = ONES;            end
            4'd8:  begin op_x = in_a;           op_y = in_a & in_b;     end
            4'd9:  begin op_x = in_a;           op_y = in_b;            end
            4'd10: begin op_x = in_a | ~in_b;   op_y = in_a & in_b;     end
            4'd11: begin op_x = in_a & in_b;    op_y = ONES;            end
            4'd12: begin op_x = in_a;           op_y = in_a;            end
            4'd13: begin op_x = in_a | in_b;    op_y = in_a;            end
            4'd14: begin op_x = in_a | ~in_b;   op_y = in_a;            end
            default: begin op_x = in_a;         op_y = ONES;            end
        endcase
    end

    assign sum = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin_eff};

    always_comb begin
        logic_res = '0;
        case (in_sel)
            4'd0:  logic_res = ~in_a;
            4'd1:  logic_res = ~(in_a | in_b);
            4'd2:  logic_res = ~in_a & in_b;
            4'd3:  logic_res = '0;
            4'd4:  logic_res = ~(in_a & in_b);
            4'd5:  logic_res = ~in_b;
            4'd6:  logic_res = in_a ^ in_b;
            4'd7:  logic_res = in_a & ~in_b;
            4'd8:  logic_res = ~in_a | in_b;
            4'd9:  logic_res = ~(in_a ^ in_b);
            4'd10: logic_res = in_b;
            4'd11: logic_res = in_a & in_b;
            4'd12: logic_res = ONES;
            4'd13: logic_res = in_a | ~in_b;
            4'd14: logic_res = in_a | in_b;
            default: logic_res = in_a;
        endcase
    end

    assign nxt_result = in_mode ? logic_res : sum[WIDTH-1:0];
    assign nxt_cout   = !in_mode && sum[WIDTH];

`ifdef ALU_PIPE_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit; compare it with the carry out.
    logic nxt_ovf;
    assign nxt_ovf = !in_mode && ((op_x[WIDTH-1] ^ op_y[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (accept) begin
            out_ovf <= nxt_ovf;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_zero   <= 1'b1;
            out_neg    <= 1'b0;
            out_equal  <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_result <= nxt_result;
                out_cout   <= nxt_cout;
                out_zero   <= (nxt_result == '0);
                out_neg    <= nxt_result[WIDTH-1];
                out_equal  <= (in_a == in_b);
                if (!in_mode) begin
                    carry_q <= sum[WIDTH];
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed vector table,
// hand-written backpressure / reset sequences, and a randomized run
// against an arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_chain;
    logic         in_mode;
    logic [3:0]   in_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout;
    logic         out_zero;
    logic         out_neg;
    logic         out_equal;
`ifdef ALU_PIPE_OVF_EN
    logic         out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_chain   (in_chain),
        .in_mode    (in_mode),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`ifdef ALU_PIPE_OVF_EN
        .out_ovf    (out_ovf),
`endif
        .out_equal  (out_equal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         mode;
        logic [3:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         chain;
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         neg;
        logic         eq;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } ref_t;

    // Reference: plain integer arithmetic on the operand pair given by the function table.
    function automatic ref_t ref_alu(input logic mode, input logic [3:0] sel,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
        ref_t r;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] ones;
        int us;
        int ss;
        ones = '1;
        r.res = '0; r.cout = 1'b0; r.ovf = 1'b0;
        if (!mode) begin
            case (sel)
                0:  begin x = a;      y = 0;      end
                1:  begin x = a | b;  y = 0;      end
                2:  begin x = a | ~b; y = 0;      end
                3:  begin x = ones;   y = 0;      end
                4:  begin x = a;      y = a & ~b; end
                5:  begin x = a | b;  y = a & ~b; end
                6:  begin x = a;      y = ~b;     end
                7:  begin x = a & ~b; y = ones;   end
                8:  begin x = a;      y = a & b;  end
                9:  begin x = a;      y = b;      end
                10: begin x = a | ~b; y = a & b;  end
                11: begin x = a & b;  y = ones;   end
                12: begin x = a;      y = a;      end
                13: begin x = a | b;  y = a;      end
                14: begin x = a | ~b; y = a;      end
                default: begin x = a; y = ones;   end
            endcase
            us = int'(x) + int'(y) + int'(c);
            ss = int'($signed(x)) + int'($signed(y)) + int'(c);
            r.res  = us[W-1:0];
            r.cout = (us >= (1 << W));
            r.ovf  = (ss > 32767) || (ss < -32768);
        end else begin
            case (sel)
                0:  r.res = ~a;
                1:  r.res = ~(a | b);
                2:  r.res = ~a & b;
                3:  r.res = 0;
                4:  r.res = ~(a & b);
                5:  r.res = ~b;
                6:  r.res = a ^ b;
                7:  r.res = a & ~b;
                8:  r.res = ~a | b;
                9:  r.res = ~(a ^ b);
                10: r.res = b;
                11: r.res = a & b;
                12: r.res = ones;
                13: r.res = a | ~b;
                14: r.res = a | b;
                default: r.res = a;
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic mode, input logic [3:0] sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic chain);
        in_valid = 1'b1;
        in_mode  = mode;
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_chain = chain;
    endtask

    vec_t vecs[12];

    // Random-run model state
    logic         m_full;
    logic         m_carry;
    ref_t         m_out;
    logic         m_eq;
    ref_t         rr;
    logic         c_eff;

    initial begin
        //            mode sel a        b        cin ch  res      co z  n  eq ovf
        vecs[0]  = '{0, 9,  16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 1, 0, 0, 0};
        vecs[1]  = '{0, 9,  16'h0000, 16'h0000, 0, 1, 16'h0001, 0, 0, 0, 1, 0};
        vecs[2]  = '{0, 6,  16'h0005, 16'h0003, 1, 0, 16'h0002, 1, 0, 0, 0, 0};
        vecs[3]  = '{1, 6,  16'h00F0, 16'h0FF0, 0, 0, 16'h0F00, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0,  16'h0000, 16'h0000, 0, 1, 16'h0001, 0, 0, 0, 1, 0};
        vecs[5]  = '{0, 3,  16'h1234, 16'h1234, 0, 0, 16'hFFFF, 0, 0, 1, 1, 0};
        vecs[6]  = '{0, 3,  16'h0000, 16'h0005, 1, 0, 16'h0000, 1, 1, 0, 0, 0};
        vecs[7]  = '{1, 12, 16'h0000, 16'h0000, 1, 0, 16'hFFFF, 0, 0, 1, 1, 0};
        vecs[8]  = '{1, 3,  16'hABCD, 16'h0001, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        vecs[9]  = '{0, 15, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 0, 0, 1, 1, 0};
        vecs[10] = '{0, 12, 16'h8000, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 1};
        vecs[11] = '{0, 9,  16'h7FFF, 16'h0000, 0, 1, 16'h8000, 0, 0, 1, 0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0); in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_cout", out_cout, 0);
        chk("rst_zero", out_zero, 1);
        chk("rst_neg", out_neg, 0);
        chk("rst_equal", out_equal, 0);
`ifdef ALU_PIPE_OVF_EN
        chk("rst_ovf", out_ovf, 0);
`endif
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Directed vector table (ordered: chained entries depend on earlier carries)
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].chain);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("v%0d_cout", i), out_cout, vecs[i].cout);
            chk($sformatf("v%0d_zero", i), out_zero, vecs[i].zero);
            chk($sformatf("v%0d_neg", i), out_neg, vecs[i].neg);
            chk($sformatf("v%0d_equal", i), out_equal, vecs[i].eq);
`ifdef ALU_PIPE_OVF_EN
            chk($sformatf("v%0d_ovf", i), out_ovf, vecs[i].ovf);
`endif
        end

        // Backpressure: second op stalls while first result is held, then flows with no bubble
        @(negedge clk);
        out_ready = 1'b0;
        drive(0, 9, 16'h0001, 16'h0002, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_result", out_result, 16'h0003);
        drive(0, 9, 16'h000A, 16'h0014, 0, 0);
        #1 chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_result", out_result, 16'h0003);
        chk("bp_hold_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1 chk("bp_in_ready_comb", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_result", out_result, 16'h001E);
        @(posedge clk);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Reset with a pending result and carry_q=1, then a chained op must see carry 0
        out_ready = 1'b0;
        drive(0, 9, 16'hFFFF, 16'h0001, 0, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_pending", out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_valid", out_valid, 0);
        chk("mr_zero", out_zero, 1);
        chk("mr_cout", out_cout, 0);
        chk("mr_in_ready", in_ready, 1);
        out_ready = 1'b1;
        drive(0, 0, 16'h1234, 16'h0000, 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_chain_result", out_result, 16'h1234);
        chk("mr_chain_cout", out_cout, 0);

        // Randomized run against the reference model; carry register starts at 0 after reset
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_full = 1'b0; m_carry = 1'b0; m_eq = 1'b0;
        m_out.res = '0; m_out.cout = 1'b0; m_out.ovf = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            chk("rnd_valid", out_valid, m_full);
            if (m_full) begin
                chk("rnd_result", out_result, m_out.res);
                chk("rnd_cout", out_cout, m_out.cout);
                chk("rnd_zero", out_zero, m_out.res == 0);
                chk("rnd_neg", out_neg, m_out.res[W-1]);
                chk("rnd_equal", out_equal, m_eq);
`ifdef ALU_PIPE_OVF_EN
                chk("rnd_ovf", out_ovf, m_out.ovf);
`endif
            end
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  16'($urandom), ($urandom_range(0, 7) == 0) ? in_a : 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1 chk("rnd_in_ready", in_ready, !m_full || out_ready);
            if (in_valid && (!m_full || out_ready)) begin
                c_eff = in_chain ? m_carry : in_cin;
                rr = ref_alu(in_mode, in_sel, in_a, in_b, c_eff);
                m_out  = rr;
                m_eq   = (in_a == in_b);
                m_full = 1'b1;
                if (!in_mode) m_carry = rr.cout;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
